// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Sequences the multicycle multiply/divide unit for R-type mul/div leaving
// decode. It latches the operands and destination, pulses the unit's start,
// stalls the pipeline while the unit works, then arbitrates for the shared
// register-file write port to write back either the result or an exception
// code into the rstatus register.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   issue_valid, opcode, aluop, rd decoded instruction in D/X
//   operand_a, operand_b           rs/rt values
//   stall                          hold fetch/decode/D-X
//   md_start_mult, md_start_div    one-cycle start pulses to the unit
//   md_operand_a, md_operand_b     latched operands to the unit
//   md_result, md_ready            unit result and its one-cycle valid pulse
//   md_exception                   overflow/div-by-zero, valid with md_ready
//   wb_req, wb_grant               write-port request / grant
//   wb_rd, wb_data                 write register index and data
//   busy                           controller is not idle
module multdiv_ctrl #(
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_REG = 30,
  parameter int MUL_EXC     = 4,
  parameter int DIV_EXC     = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        stall,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        wb_req,
  input  logic        wb_grant,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  count;
  logic [4:0]     rd_q;
  logic           kind_div;
  logic [31:0]    result_q;
  logic           exc_q;
  logic           match;
  logic           timeout;
  logic           completing;

  assign match   = issue_valid && (opcode == 5'd0) && ((aluop == 5'd6) || (aluop == 5'd7));
  assign timeout = (count == CW'(TIMEOUT - 1));

  // A non-exception result headed for r0 is dropped, so write-back finishes
  // without ever touching the write port.
  assign completing = wb_grant || ((rd_q == 5'd0) && !exc_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    wb_req        = 1'b0;
    wb_rd         = 5'd0;
    wb_data       = 32'd0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        stall = match;
        if (match) begin
          state_next = START;
        end
      end
      START: begin
        stall         = 1'b1;
        md_start_mult = !kind_div;
        md_start_div  = kind_div;
        state_next    = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (md_ready || timeout) begin
          state_next = WB;
        end
      end
      WB: begin
        if (exc_q) begin
          wb_rd   = 5'(RSTATUS_REG);
          wb_data = kind_div ? 32'(DIV_EXC) : 32'(MUL_EXC);
        end else begin
          wb_rd   = rd_q;
          wb_data = result_q;
        end
        wb_req = exc_q || (rd_q != 5'd0);
        // Stall drops in the completing cycle so the mul/div leaves D/X on
        // this edge and is not detected a second time.
        stall = !completing;
        if (completing) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/destination capture, WAIT cycle counter and result latch. A
  // ready in the same cycle as the timeout takes priority and keeps the
  // unit's own exception bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_operand_a <= 32'd0;
      md_operand_b <= 32'd0;
      rd_q         <= 5'd0;
      kind_div     <= 1'b0;
      count        <= '0;
      result_q     <= 32'd0;
      exc_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            md_operand_a <= operand_a;
            md_operand_b <= operand_b;
            rd_q         <= rd;
            kind_div     <= aluop[0];
            exc_q        <= 1'b0;
          end
        end
        START: begin
          count <= '0;
        end
        WAIT: begin
          count <= count + 1'b1;
          if (md_ready) begin
            result_q <= md_result;
            exc_q    <= md_exception;
          end else if (timeout) begin
            exc_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
